regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the RV32 pipelined core family. It has configurable width, depth and read-port count, an optional hardwired zero register, and a per-register busy scoreboard. The issue stage reserves a destination, and writeback clears the reservation. It replaces the fixed 32x32, 2-read-port file. The decode/issue stage reads it, and writeback drives its single write port.

---
 rtl/regfile_mp.sv | 96 +++++++++
 tb/tb_regfile_mp.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    input  logic                     flush,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     any_busy
);

    // Register 0 has no storage when it is hardwired to zero.
    localparam int unsigned FIRST = ZERO_REG ? 1 : 0;

    logic [WIDTH-1:0] mem [FIRST:DEPTH-1];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic             wr_ok;
    logic             rsv_ok;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    assign wr_ok  = wr_en  && addr_ok(wr_addr);
    assign rsv_ok = rsv_en && addr_ok(rsv_addr);

    // Reserve is applied after the write clear so a new producer keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (wr_ok) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (flush) begin
            busy_next = '0;
        end else if (rsv_ok) begin
            busy_next[rsv_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem      <= '{default: '0};
            busy     <= '0;
            any_busy <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
            busy     <= busy_next;
            any_busy <= |busy_next;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] data_i;
        logic             busy_i;

        assign a = rd_addr[i*AW +: AW];

        always_comb begin
            data_i = '0;
            busy_i = 1'b0;
            if (addr_ok(a)) begin
                data_i = mem[a];
                busy_i = busy[a];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (wr_addr == a)) begin
                    data_i = wr_data;
                    busy_i = rsv_ok && !flush && (rsv_addr == a);
                end
`endif
            end
        end

        assign rd_data[i*WIDTH +: WIDTH] = data_i;
        assign rd_busy[i]                = busy_i;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32/2-port instance plus a 24-entry 3-port instance.
module tb_regfile_mp;

    logic        clk;
    logic        rst;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        any_busy;

    logic        wr_en2;
    logic [4:0]  wr_addr2;
    logic [31:0] wr_data2;
    logic        rsv_en2;
    logic [4:0]  rsv_addr2;
    logic        flush2;
    logic [14:0] rd_addr2;
    logic [95:0] rd_data2;
    logic [2:0]  rd_busy2;
    logic        any_busy2;

    int n_vec;
    int n_err;

    regfile_mp u_dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .any_busy (any_busy)
    );

    regfile_mp #(
        .DEPTH  (24),
        .NUM_RD (3)
    ) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en2),
        .wr_addr  (wr_addr2),
        .wr_data  (wr_data2),
        .rsv_en   (rsv_en2),
        .rsv_addr (rsv_addr2),
        .flush    (flush2),
        .rd_addr  (rd_addr2),
        .rd_data  (rd_data2),
        .rd_busy  (rd_busy2),
        .any_busy (any_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rsv_en  = 1'b0;
        flush   = 1'b0;
        wr_en2  = 1'b0;
        rsv_en2 = 1'b0;
        flush2  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        rd_addr = {5'd6, 5'd5};
        #1;
        n_vec++;
        if (rd_data[31:0] !== 32'h0) begin
            n_err++;
            $display("FAIL reset_init_data: got %h want %h", rd_data[31:0], 32'h0);
        end
        n_vec++;
        if (any_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init_any_busy: got %b want 0", any_busy);
        end

        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rsv_en = 1'b1; rsv_addr = 5'd6;
        cyc();
        idle();
        #1;
        n_vec++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL reset_pre_data: got %h want %h", rd_data[31:0], 32'hDEADBEEF);
        end
        n_vec++;
        if (rd_busy[1] !== 1'b1 || any_busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_busy: got busy=%b any=%b want 1 1", rd_busy[1], any_busy);
        end

        // Reset overrides same-cycle write and reserve.
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h00000001;
        rsv_en = 1'b1; rsv_addr = 5'd8;
        cyc();
        rst = 1'b0;
        idle();
        #1;
        n_vec++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_clear_x5: got data=%h busy=%b want 00000000 0", rd_data[31:0], rd_busy[0]);
        end
        n_vec++;
        if (rd_busy[1] !== 1'b0 || any_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_clear_busy: got x6busy=%b any=%b want 0 0", rd_busy[1], any_busy);
        end
        rd_addr = {5'd8, 5'd5};
        #1;
        n_vec++;
        if (rd_busy[1] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rsv_override: got %b want 0", rd_busy[1]);
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        cyc();
        idle();
        #1;
        n_vec++;
        if (rd_data !== 64'h0) begin
            n_err++;
            $display("FAIL zero_reg_data: got %h want %h", rd_data, 64'h0);
        end
        n_vec++;
        if (rd_busy !== 2'b00 || any_busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_reg_busy: got busy=%b any=%b want 00 0", rd_busy, any_busy);
        end
    endtask

    task automatic test_scoreboard();
        rd_addr = {5'd7, 5'd7};
        rsv_en = 1'b1; rsv_addr = 5'd7;
        cyc();
        idle();
        #1;
        n_vec++;
        if (rd_busy !== 2'b11 || any_busy !== 1'b1) begin
            n_err++;
            $display("FAIL sb_busy_n1: got busy=%b any=%b want 11 1", rd_busy, any_busy);
        end
        cyc();
        n_vec++;
        if (rd_busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_busy_n2: got %b want 1", rd_busy[0]);
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        cyc();
        idle();
        #1;
        n_vec++;
        if (rd_busy[0] !== 1'b0 || any_busy !== 1'b0) begin
            n_err++;
            $display("FAIL sb_busy_n3: got busy=%b any=%b want 0 0", rd_busy[0], any_busy);
        end
        n_vec++;
        if (rd_data[31:0] !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL sb_data_n3: got %h want %h", rd_data[31:0], 32'hA5A5A5A5);
        end

        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h5A5A5A5A;
        rsv_en = 1'b1; rsv_addr = 5'd7;
        cyc();
        idle();
        #1;
        n_vec++;
        if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h5A5A5A5A || any_busy !== 1'b1) begin
            n_err++;
            $display("FAIL sb_same_cycle: got busy=%b data=%h any=%b want 1 5a5a5a5a 1",
                     rd_busy[0], rd_data[31:0], any_busy);
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000011;
        cyc();
        idle();
        #1;
        n_vec++;
        if (rd_busy[0] !== 1'b0 || any_busy !== 1'b0) begin
            n_err++;
            $display("FAIL sb_release: got busy=%b any=%b want 0 0", rd_busy[0], any_busy);
        end
    endtask

    task automatic test_flush();
        rsv_en = 1'b1; rsv_addr = 5'd3;
        cyc();
        rsv_addr = 5'd4;
        cyc();
        idle();
        rd_addr = {5'd4, 5'd3};
        #1;
        n_vec++;
        if (rd_busy !== 2'b11 || any_busy !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pre: got busy=%b any=%b want 11 1", rd_busy, any_busy);
        end
        flush = 1'b1;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000CAFE;
        cyc();
        idle();
        #1;
        n_vec++;
        if (rd_busy !== 2'b00 || any_busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear: got busy=%b any=%b want 00 0", rd_busy, any_busy);
        end
        rd_addr = {5'd12, 5'd9};
        #1;
        n_vec++;
        if (rd_busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL flush_rsv_ignored: got %b want 0", rd_busy[0]);
        end
        n_vec++;
        if (rd_data[63:32] !== 32'h0000CAFE) begin
            n_err++;
            $display("FAIL flush_write: got %h want %h", rd_data[63:32], 32'h0000CAFE);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        logic        exp_busy;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h2;
        exp_busy = 1'b0;
`else
        exp_same = 32'h1;
        exp_busy = 1'b1;
`endif
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h1;
        cyc();
        rd_addr = {5'd10, 5'd10};
        wr_data = 32'h2;
        #1;
        n_vec++;
        if (rd_data[31:0] !== exp_same || rd_data[63:32] !== exp_same) begin
            n_err++;
            $display("FAIL bypass_same_cycle: got %h %h want %h", rd_data[31:0], rd_data[63:32], exp_same);
        end
        cyc();
        idle();
        #1;
        n_vec++;
        if (rd_data !== {32'h2, 32'h2}) begin
            n_err++;
            $display("FAIL bypass_next_cycle: got %h want %h", rd_data, {32'h2, 32'h2});
        end

        rsv_en = 1'b1; rsv_addr = 5'd11;
        cyc();
        idle();
        rd_addr = {5'd10, 5'd11};
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h3;
        #1;
        n_vec++;
        if (rd_busy[0] !== exp_busy) begin
            n_err++;
            $display("FAIL bypass_busy: got %b want %b", rd_busy[0], exp_busy);
        end
        cyc();
        idle();
        #1;
        n_vec++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h3) begin
            n_err++;
            $display("FAIL bypass_after: got busy=%b data=%h want 0 00000003", rd_busy[0], rd_data[31:0]);
        end
    endtask

    task automatic test_nonpow2();
        wr_en2 = 1'b1; wr_addr2 = 5'd23; wr_data2 = 32'h77;
        cyc();
        wr_addr2 = 5'd30; wr_data2 = 32'hFF;
        rsv_en2 = 1'b1; rsv_addr2 = 5'd30;
        cyc();
        idle();
        rd_addr2 = {5'd14, 5'd23, 5'd30};
        #1;
        n_vec++;
        if (rd_data2[31:0] !== 32'h0 || rd_busy2[0] !== 1'b0) begin
            n_err++;
            $display("FAIL np2_oob: got data=%h busy=%b want 00000000 0", rd_data2[31:0], rd_busy2[0]);
        end
        n_vec++;
        if (rd_data2[63:32] !== 32'h77) begin
            n_err++;
            $display("FAIL np2_last: got %h want %h", rd_data2[63:32], 32'h77);
        end
        n_vec++;
        if (rd_data2[95:64] !== 32'h0 || any_busy2 !== 1'b0) begin
            n_err++;
            $display("FAIL np2_no_alias: got x14=%h any=%b want 00000000 0", rd_data2[95:64], any_busy2);
        end
        rsv_en2 = 1'b1; rsv_addr2 = 5'd23;
        cyc();
        idle();
        #1;
        n_vec++;
        if (rd_busy2 !== 3'b010 || any_busy2 !== 1'b1) begin
            n_err++;
            $display("FAIL np2_rsv_last: got busy=%b any=%b want 010 1", rd_busy2, any_busy2);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        wr_addr  = '0; wr_data  = '0; rsv_addr  = '0; rd_addr  = '0;
        wr_addr2 = '0; wr_data2 = '0; rsv_addr2 = '0; rd_addr2 = '0;
        idle();
        test_reset();
        test_zero_reg();
        test_scoreboard();
        test_flush();
        test_bypass();
        test_nonpow2();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
